seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Buffers a hex word plus decimal points, and scans digits at a programmable slot rate with an anti-ghosting guard cycle.
- Adds leading-zero blanking and per-digit blink.
- Sits between the clock/counter logic and the board display pins, replacing per-digit static decoders.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (1..16)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period; 0 disables blinking
SEG_ACTIVE_LOW, 1, 1: seg_o/dp_o lit when 0; 0: lit when 1
AN_ACTIVE_LOW, 1, 1: an_o enables a digit when 0; 0: enables when 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
digits_i  input  4*NUM_DIGITS  hex nibbles; nibble k = digit k, k=0 is least significant (rightmost)
dp_i  input  NUM_DIGITS  decimal point request per digit
blink_mask_i  input  NUM_DIGITS  digits to blink
blank_lz_i  input  1  enable leading-zero blanking
load_i  input  1  capture digits_i/dp_i/blink_mask_i/blank_lz_i into the pending buffer
seg_o  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp_o  output  1  decimal point segment
an_o  output  NUM_DIGITS  digit enables, one-hot when active
frame_o  output  1  one-cycle pulse at start of each digit-0 slot

Behaviour:
- Reset (rst_n=0 at an edge):
  - seg_o, dp_o and an_o all in the unlit/disabled level.
  - frame_o=0.
  - Slot counter, digit index, frame counter and blink phase cleared to 0.
  - Pending and display buffers cleared to all-zero (digits 0, dp 0, mask 0, blank_lz 0); pending-valid flag cleared.
  - Reset mid-scan aborts the slot immediately.
- Glyphs, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Inverted when SEG_ACTIVE_LOW=1.
- Scan timing (as seen at the outputs, all registered):
  - Each slot lasts exactly SCAN_DIV cycles.
  - Slot cycle 0 is the guard cycle: an_o all disabled; seg_o/dp_o already show the new digit's pattern.
  - Cycles 1..SCAN_DIV-1: an_o enables only digit idx.
  - idx runs 0,1,..,NUM_DIGITS-1, then wraps to 0.
  - The first slot after reset release is digit 0 and begins on the first edge with rst_n=1.
- frame_o: high during the guard cycle of every digit-0 slot, including the first one after reset.
- Buffering (tear-free updates):
  - load_i=1 copies the inputs into the pending buffer and sets pending-valid. The most recent load wins.
  - At each frame boundary (the cycle the digit-0 slot begins), the display buffer takes the pending contents if pending-valid was set, and pending-valid clears.
  - If load_i=1 in the boundary cycle itself, the inputs go straight into the display buffer (bypass) and pending-valid clears.
  - A digit never changes within a frame.
- Leading-zero blanking, evaluated on the display buffer:
  - With blank_lz=1, digit k>0 is blanked when it and every digit above it are 0.
  - Digit 0 is never blanked.
  - A blanked digit forces seg_o unlit; dp_o still follows dp.
- Blink:
  - The frame counter increments at each frame boundary.
  - After BLINK_FRAMES frames the counter clears and blink phase toggles.
  - While phase=1, digits with mask=1 force seg_o and dp_o unlit; an_o timing is unchanged.
  - Phase starts at 0 (visible).
  - With BLINK_FRAMES=0 the phase is held at 0.
- Widths:
  - Slot counter: $clog2(SCAN_DIV) bits.
  - Index: $clog2(NUM_DIGITS), minimum 1 bit.
  - Frame counter: $clog2(BLINK_FRAMES+1), minimum 1 bit.
  - All counters wrap by compare-and-clear, never by natural overflow.

Decomposition:
- seg7_pkg:
  - 16-entry glyph constant array (active-high).
  - SEG_BLANK constant.
  - Polarity helper function.
- Sub-module seg7_hex_decode: combinational nibble to glyph lookup from the package. Instantiated once, fed by the currently indexed nibble.
- The top holds all counters, buffers and output registers.

Test Plan:
(All cases use NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, both polarities active-low.)
- Reset: hold rst_n=0 for 3 cycles -> seg_o=7F, dp_o=1, an_o=F, frame_o=0. On release: frame_o=1 in the first cycle and an_o=E for the next 3 cycles.
- Scan order: load digits_i=16'h1234 and wait 2 frames -> repeating sequence:
  - seg_o=19 (4) with an_o=F,E,E,E
  - seg_o=30 (3) with an_o=F,D,D,D
  - seg_o=24 (2) with an_o=F,B,B,B
  - seg_o=79 (1) with an_o=F,7,7,7
  - frame period 16 cycles.
- Tear-free load: pulse load_i with 16'hABCD at digit-2 slot, then load_i with 16'h00F0 one cycle later -> the current frame completes showing the old value; the next frame shows 00F0; ABCD never appears.
- Leading zeros: load 16'h0040 with blank_lz_i=1 and dp_i=4'b1000 -> digits 3 and 2 show seg_o=7F; digit 3 shows dp_o=0; digit 1 shows 19; digit 0 shows 40.
- Blink: load blink_mask_i=4'b0001 -> digit 0 visible for frames 0-1, unlit for frames 2-3, visible again for frames 4-5; an_o timing unchanged.
- Bypass and reset mid-scan:
  - load_i coincident with frame_o -> the new value is displayed in that same frame.
  - Assert rst_n=0 mid-slot -> outputs unlit at the next edge; the sequence restarts from digit 0 showing 0 (seg_o=40).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table,
// blank pattern and a polarity helper for the segment bus.
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // All segments dark (active-high form).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Convert an active-high segment pattern to the pin level.
    function automatic logic [6:0] seg_pol(input logic [6:0] pat, input logic act_low);
        return act_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPH[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: tear-free double buffer, per-digit
// scan with a guard cycle, leading-zero blanking and per-digit blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    input  logic                    blank_lz_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
    localparam int DW     = 4 * NUM_DIGITS;

    localparam logic                  SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_LOW  = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = seg_pol(SEG_BLANK, SEG_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_LOW}};

    // Scan position of the slot the next edge will present.
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_q, phase_d;

    // Pending (written any time) and display (frame-stable) buffers.
    logic [DW-1:0]         pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d, disp_mask_q, disp_mask_d;
    logic                  pend_lz_q, pend_lz_d, disp_lz_q, disp_lz_d;
    logic                  pend_vld_q, pend_vld_d;

    // Registered pin drivers.
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  boundary;
    logic                  slot_last;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_above;
    logic                  blink_off;
    logic                  seg_dark;
    logic                  dp_lit;
    logic [NUM_DIGITS-1:0] an_onehot;

    seg7_hex_decode u_dec (
        .nib_i  (cur_nib),
        .glyph_o(glyph)
    );

    // Next-state for scan counters, buffers and blink phase.
    always_comb begin
        slot_last   = (slot_q == SLOT_W'(SCAN_DIV - 1));
        boundary    = (slot_q == '0) && (idx_q == '0);
        slot_d      = slot_last ? '0 : slot_q + 1'b1;
        idx_d       = idx_q;
        if (slot_last)
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

        pend_dig_d  = pend_dig_q;
        pend_dp_d   = pend_dp_q;
        pend_mask_d = pend_mask_q;
        pend_lz_d   = pend_lz_q;
        pend_vld_d  = pend_vld_q;
        disp_dig_d  = disp_dig_q;
        disp_dp_d   = disp_dp_q;
        disp_mask_d = disp_mask_q;
        disp_lz_d   = disp_lz_q;
        fcnt_d      = fcnt_q;
        phase_d     = phase_q;

        if (boundary) begin
            // A load on the boundary edge bypasses straight to the display.
            pend_vld_d = 1'b0;
            if (load_i) begin
                disp_dig_d  = digits_i;
                disp_dp_d   = dp_i;
                disp_mask_d = blink_mask_i;
                disp_lz_d   = blank_lz_i;
            end else if (pend_vld_q) begin
                disp_dig_d  = pend_dig_q;
                disp_dp_d   = pend_dp_q;
                disp_mask_d = pend_mask_q;
                disp_lz_d   = pend_lz_q;
            end
            // Counter holds frames shown in the current phase; the frame that
            // starts on a toggle is the first of the new phase.
            if (BLINK_FRAMES > 0) begin
                if (fcnt_q == FCNT_W'(BLINK_FRAMES)) begin
                    fcnt_d  = FCNT_W'(1);
                    phase_d = ~phase_q;
                end else begin
                    fcnt_d  = fcnt_q + 1'b1;
                end
            end
        end else if (load_i) begin
            pend_dig_d  = digits_i;
            pend_dp_d   = dp_i;
            pend_mask_d = blink_mask_i;
            pend_lz_d   = blank_lz_i;
            pend_vld_d  = 1'b1;
        end
    end

    // Output pattern for the slot being presented, from the post-update buffer.
    always_comb begin
        cur_nib    = disp_dig_d[idx_q*4 +: 4];
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above & (disp_dig_d[k*4 +: 4] == 4'h0);
            lz_blank[k] = disp_lz_d & zero_above;
        end
        blink_off  = phase_d & disp_mask_d[idx_q];
        seg_dark   = lz_blank[idx_q] | blink_off;
        dp_lit     = disp_dp_d[idx_q] & ~blink_off;
        an_onehot  = '0;
        if (slot_q != '0)
            an_onehot[idx_q] = 1'b1;

        seg_d   = seg_pol(seg_dark ? SEG_BLANK : glyph, SEG_LOW);
        dp_d    = SEG_LOW ? ~dp_lit : dp_lit;
        an_d    = AN_LOW ? ~an_onehot : an_onehot;
        frame_d = boundary;
    end

    // State registers; reset restarts the scan at digit 0 with cleared buffers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q      <= '0;
            idx_q       <= '0;
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            pend_dig_q  <= '0;
            pend_dp_q   <= '0;
            pend_mask_q <= '0;
            pend_lz_q   <= 1'b0;
            pend_vld_q  <= 1'b0;
            disp_dig_q  <= '0;
            disp_dp_q   <= '0;
            disp_mask_q <= '0;
            disp_lz_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            pend_dig_q  <= pend_dig_d;
            pend_dp_q   <= pend_dp_d;
            pend_mask_q <= pend_mask_d;
            pend_lz_q   <= pend_lz_d;
            pend_vld_q  <= pend_vld_d;
            disp_dig_q  <= disp_dig_d;
            disp_dp_q   <= disp_dp_d;
            disp_mask_q <= disp_mask_d;
            disp_lz_q   <= disp_lz_d;
        end
    end

    // Output registers; reset drives every pin to its dark/disabled level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_LOW;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, 2-frame blink.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blink_mask_i = '0;
    logic        blank_lz_i = 1'b0;
    logic        load_i = 1'b0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int checks = 0;
    int passed = 0;
    int cyc = 0;   // cycles since the first edge after reset release

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i),
        .blink_mask_i(blink_mask_i), .blank_lz_i(blank_lz_i), .load_i(load_i),
        .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Step at least one cycle, then until cyc%16 == m (bounded).
    task automatic advance_to(input int m);
        tick();
        for (int n = 0; n < 32 && (cyc % 16) != m; n++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (seg_o !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg_o); else passed++;
        checks++; if (dp_o !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp_o); else passed++;
        checks++; if (an_o !== 4'hF) $display("FAIL reset_an: got %h want f", an_o); else passed++;
        checks++; if (frame_o !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame_o); else passed++;
        rst_n = 1'b1;
        cyc = -1;
        tick();
        checks++; if (frame_o !== 1'b1) $display("FAIL release_frame: got %b want 1", frame_o); else passed++;
        checks++; if (an_o !== 4'hF) $display("FAIL release_guard_an: got %h want f", an_o); else passed++;
        checks++; if (seg_o !== 7'h40) $display("FAIL release_seg: got %h want 40", seg_o); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (an_o !== 4'hE) $display("FAIL release_an%0d: got %h want e", i, an_o); else passed++;
            checks++; if (frame_o !== 1'b0) $display("FAIL release_frame%0d: got %b want 0", i, frame_o); else passed++;
        end
    endtask

    task automatic test_scan();
        logic [6:0] tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [3:0] exp_an;
        digits_i = 16'h1234; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        advance_to(15);
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_an = ((i % 4) == 0) ? 4'hF : ~(4'b0001 << ((i % 16) / 4));
            checks++; if (seg_o !== tab[(i % 16) / 4]) $display("FAIL scan_seg%0d: got %h want %h", i, seg_o, tab[(i % 16) / 4]); else passed++;
            checks++; if (an_o !== exp_an) $display("FAIL scan_an%0d: got %h want %h", i, an_o, exp_an); else passed++;
            checks++; if (frame_o !== ((i % 16) == 0)) $display("FAIL scan_frame%0d: got %b want %b", i, frame_o, (i % 16) == 0); else passed++;
        end
    endtask

    task automatic test_tearfree();
        logic [6:0] old_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [6:0] new_tab [4] = '{7'h40, 7'h0E, 7'h40, 7'h40};
        advance_to(8);
        digits_i = 16'hABCD; load_i = 1'b1;
        tick();
        digits_i = 16'h00F0;
        tick();
        load_i = 1'b0;
        for (int n = 0; n < 16 && (cyc % 16) != 15; n++) begin
            tick();
            checks++; if (seg_o !== old_tab[(cyc % 16) / 4]) $display("FAIL tear_old_c%0d: got %h want %h", cyc, seg_o, old_tab[(cyc % 16) / 4]); else passed++;
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (seg_o !== new_tab[i / 4]) $display("FAIL tear_new%0d: got %h want %h", i, seg_o, new_tab[i / 4]); else passed++;
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] seg_tab [4] = '{7'h40, 7'h19, 7'h7F, 7'h7F};
        logic       dp_tab  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tick();
        digits_i = 16'h0040; blank_lz_i = 1'b1; dp_i = 4'b1000; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        advance_to(15);
        for (int i = 0; i < 16; i++) begin
            tick();
            if ((i % 4) == 1) begin
                checks++; if (seg_o !== seg_tab[i / 4]) $display("FAIL lz_seg_d%0d: got %h want %h", i / 4, seg_o, seg_tab[i / 4]); else passed++;
                checks++; if (dp_o !== dp_tab[i / 4]) $display("FAIL lz_dp_d%0d: got %b want %b", i / 4, dp_o, dp_tab[i / 4]); else passed++;
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_seg;
        digits_i = 16'h0000; dp_i = 4'b0000; blank_lz_i = 1'b0;
        blink_mask_i = 4'b0001; load_i = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        cyc = -1;
        tick();
        load_i = 1'b0;
        for (int f = 0; f < 6; f++) begin
            advance_to(1);
            exp_seg = (((f / 2) % 2) == 1) ? 7'h7F : 7'h40;
            checks++; if (seg_o !== exp_seg) $display("FAIL blink_seg_f%0d: got %h want %h", f, seg_o, exp_seg); else passed++;
            checks++; if (an_o !== 4'hE) $display("FAIL blink_an_f%0d: got %h want e", f, an_o); else passed++;
            checks++; if (dp_o !== 1'b1) $display("FAIL blink_dp_f%0d: got %b want 1", f, dp_o); else passed++;
            if (f == 2) begin
                advance_to(5);
                checks++; if (seg_o !== 7'h40) $display("FAIL blink_unmasked: got %h want 40", seg_o); else passed++;
            end
        end
    endtask

    task automatic test_bypass_reset();
        advance_to(15);
        digits_i = 16'h5678; blink_mask_i = 4'b0000; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        checks++; if (frame_o !== 1'b1) $display("FAIL bypass_frame: got %b want 1", frame_o); else passed++;
        checks++; if (seg_o !== 7'h00) $display("FAIL bypass_guard_seg: got %h want 00", seg_o); else passed++;
        tick();
        checks++; if (seg_o !== 7'h00) $display("FAIL bypass_seg: got %h want 00", seg_o); else passed++;
        advance_to(5);
        checks++; if (seg_o !== 7'h78) $display("FAIL bypass_d1_seg: got %h want 78", seg_o); else passed++;
        checks++; if (an_o !== 4'hD) $display("FAIL bypass_d1_an: got %h want d", an_o); else passed++;
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (seg_o !== 7'h7F) $display("FAIL midrst_seg: got %h want 7f", seg_o); else passed++;
        checks++; if (an_o !== 4'hF) $display("FAIL midrst_an: got %h want f", an_o); else passed++;
        checks++; if (dp_o !== 1'b1) $display("FAIL midrst_dp: got %b want 1", dp_o); else passed++;
        rst_n = 1'b1;
        cyc = -1;
        tick();
        checks++; if (frame_o !== 1'b1) $display("FAIL restart_frame: got %b want 1", frame_o); else passed++;
        checks++; if (seg_o !== 7'h40) $display("FAIL restart_seg: got %h want 40", seg_o); else passed++;
        tick();
        checks++; if (an_o !== 4'hE) $display("FAIL restart_an: got %h want e", an_o); else passed++;
        checks++; if (seg_o !== 7'h40) $display("FAIL restart_seg1: got %h want 40", seg_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearfree();
        test_leading_zero();
        test_blink();
        test_bypass_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
